// File: rtl/a25_cache_flush_ctrl.sv
// Amber 25 cache-maintenance sequencer: invalidates every tag set after reset, on CP15 flush and on cache disable.
// Optional build macro A25_FLUSH_STATS_EN adds a saturating 16-bit o_flush_count of completed walks.
module a25_cache_flush_ctrl #(
   parameter  int CACHE_LINES = 256,
   parameter  int CACHE_WAYS  = 4,
   localparam int LINE_W      = $clog2(CACHE_LINES)
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_cache_flush,
   input  logic                  i_cache_enable,
   output logic                  o_flush_stall,
   output logic                  o_tag_wr_en,
   output logic [LINE_W-1:0]     o_tag_wr_addr,
   output logic [CACHE_WAYS-1:0] o_tag_wr_way,
   output logic                  o_flush_done
`ifdef A25_FLUSH_STATS_EN
   ,
   output logic [15:0]           o_flush_count
`endif
);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_WALK,
      ST_DONE
   } state_t;

   localparam logic [LINE_W-1:0] LAST_SET = LINE_W'(CACHE_LINES - 1);

   state_t              state_q, state_d;
   logic [LINE_W-1:0]   count_q, count_d;
   logic                pending_q, pending_d;
   logic                enable_q;
   logic                trigger;

   logic                stall_d;
   logic                wr_en_d;
   logic [LINE_W-1:0]   addr_d;
   logic [CACHE_WAYS-1:0] way_d;
   logic                done_d;

   // Turning the cache off must leave no stale valid bits behind, so a disable edge acts as a flush.
   assign trigger = i_cache_flush | (enable_q & ~i_cache_enable);

   // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= ST_INIT;
         count_q   <= '0;
         pending_q <= 1'b0;
         enable_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         enable_q  <= i_cache_enable;
      end
   end

   // NOTE: every combinational output gets a default first, so no path through the case can infer a latch.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      pending_d = pending_q;
      unique case (state_q)
         ST_INIT: begin
            state_d   = ST_WALK;
            count_d   = '0;
            pending_d = trigger;
         end
         ST_IDLE: begin
            if (trigger) begin
               state_d = ST_WALK;
               count_d = '0;
            end
         end
         ST_WALK: begin
            count_d = count_q + 1'b1;
            if (count_q == LAST_SET) begin
               // A request landing on the final set folds into the re-walk instead of being dropped.
               if (pending_q || trigger) begin
                  pending_d = 1'b0;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               pending_d = pending_q | trigger;
            end
         end
         ST_DONE: begin
            count_d = '0;
            state_d = trigger ? ST_WALK : ST_IDLE;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // Outputs are a registered decode of the current state, one cycle behind the state register.
   always_comb begin
      stall_d = 1'b1;
      wr_en_d = 1'b0;
      addr_d  = '0;
      way_d   = '0;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            stall_d = 1'b0;
         end
         ST_WALK: begin
            wr_en_d = 1'b1;
            addr_d  = count_q;
            way_d   = '1;
         end
         ST_DONE: begin
            stall_d = 1'b0;
            done_d  = 1'b1;
         end
         default: begin
            stall_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_flush_stall <= 1'b1;
         o_tag_wr_en   <= 1'b0;
         o_tag_wr_addr <= '0;
         o_tag_wr_way  <= '0;
         o_flush_done  <= 1'b0;
      end else begin
         o_flush_stall <= stall_d;
         o_tag_wr_en   <= wr_en_d;
         o_tag_wr_addr <= addr_d;
         o_tag_wr_way  <= way_d;
         o_flush_done  <= done_d;
      end
   end

`ifdef A25_FLUSH_STATS_EN
   // Count moves together with the done pulse and sticks at its maximum.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_flush_count <= '0;
      end else if (done_d && (o_flush_count != 16'hFFFF)) begin
         o_flush_count <= o_flush_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_a25_cache_flush_ctrl.sv
// Directed bench for a25_cache_flush_ctrl: vector table plus hand-written multi-cycle walk sequences.
// Build with A25_FLUSH_STATS_EN defined to also cover o_flush_count.
module tb_a25_cache_flush_ctrl;

   localparam int LINES = 256;
   localparam int WAYS  = 4;

   logic       i_clk          = 1'b0;
   logic       i_reset_n      = 1'b1;
   logic       i_cache_flush  = 1'b0;
   logic       i_cache_enable = 1'b0;
   logic       o_flush_stall;
   logic       o_tag_wr_en;
   logic [7:0] o_tag_wr_addr;
   logic [3:0] o_tag_wr_way;
   logic       o_flush_done;
`ifdef A25_FLUSH_STATS_EN
   logic [15:0] o_flush_count;
`endif

   int n_vec     = 0;
   int n_err     = 0;
   int wr_seen   = 0;
   int done_seen = 0;

   a25_cache_flush_ctrl #(
      .CACHE_LINES (LINES),
      .CACHE_WAYS  (WAYS)
   ) dut (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_cache_flush  (i_cache_flush),
      .i_cache_enable (i_cache_enable),
      .o_flush_stall  (o_flush_stall),
      .o_tag_wr_en    (o_tag_wr_en),
      .o_tag_wr_addr  (o_tag_wr_addr),
      .o_tag_wr_way   (o_tag_wr_way),
      .o_flush_done   (o_flush_done)
`ifdef A25_FLUSH_STATS_EN
      ,
      .o_flush_count  (o_flush_count)
`endif
   );

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      if (o_flush_done) done_seen++;
      if (o_tag_wr_en) wr_seen++;
   end

   typedef struct {
      string name;
      logic  flush;
      logic  en;
      logic  stall;
      logic  wr_en;
      logic  done;
      logic  walk;
   } vec_t;

   task automatic step(input logic flush, input logic en);
      i_cache_flush  = flush;
      i_cache_enable = en;
      @(posedge i_clk);
      #1;
   endtask

   task automatic check_out(input string name, input logic stall, input logic wr,
                            input logic [7:0] addr, input logic done);
      logic [3:0] way;
      way = wr ? 4'hF : 4'h0;
      n_vec++;
      if ({o_flush_stall, o_tag_wr_en, o_tag_wr_addr, o_tag_wr_way, o_flush_done} !==
          {stall, wr, addr, way, done}) begin
         n_err++;
         $display("FAIL %s: got stall=%b wr_en=%b addr=%0d way=%h done=%b, expected stall=%b wr_en=%b addr=%0d way=%h done=%b",
                  name, o_flush_stall, o_tag_wr_en, o_tag_wr_addr, o_tag_wr_way, o_flush_done,
                  stall, wr, addr, way, done);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Full walk: one edge per set; flush is pulsed on the edges that show addr pa and pb.
   task automatic walk(input string tag, input int pa, input int pb, input logic en);
      for (int i = 0; i < LINES; i++) begin
         step((i == pa) || (i == pb), en);
         check_out($sformatf("%s addr %0d", tag, i), 1'b1, 1'b1, i[7:0], 1'b0);
      end
   endtask

   task automatic finish_walk(input string tag, input logic en);
      step(1'b0, en);
      check_out({tag, " done"}, 1'b0, 1'b0, 8'd0, 1'b1);
      step(1'b0, en);
      check_out({tag, " idle"}, 1'b0, 1'b0, 8'd0, 1'b0);
   endtask

   initial begin
      vec_t vecs[13];
      int   wr0;
      int   dn0;

      vecs[0]  = '{"idle",                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{"en rise",             1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{"en hold",             1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{"en fall",             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{"en fall done",        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{"idle after fall",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{"en rise again",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{"en hold 2",           1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{"en hold 3",           1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{"flush while enabled", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{"done with retrigger", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[11] = '{"retrigger done",      1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{"idle enabled",        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset and power-on walk: done pulse on edge 258 after release.
      #1 i_reset_n = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      check_out("reset hold", 1'b1, 1'b0, 8'd0, 1'b0);
      i_reset_n = 1'b1;
      wr0 = wr_seen;
      dn0 = done_seen;
      step(1'b0, 1'b0);
      check_out("init cycle", 1'b1, 1'b0, 8'd0, 1'b0);
      walk("power-on", -1, -1, 1'b0);
      finish_walk("power-on", 1'b0);
      check_int("power-on writes", wr_seen - wr0, 256);
      check_int("power-on done pulses", done_seen - dn0, 1);
`ifdef A25_FLUSH_STATS_EN
      check_int("count after power-on", int'(o_flush_count), 1);
`endif

      // Single flush from IDLE.
      wr0 = wr_seen;
      dn0 = done_seen;
      step(1'b1, 1'b0);
      check_out("flush sampled", 1'b0, 1'b0, 8'd0, 1'b0);
      walk("flush", -1, -1, 1'b0);
      finish_walk("flush", 1'b0);
      check_int("flush writes", wr_seen - wr0, 256);
      check_int("flush done pulses", done_seen - dn0, 1);

      // Flushes at addr 100 and 255 collapse into one back-to-back re-walk.
      wr0 = wr_seen;
      dn0 = done_seen;
      step(1'b1, 1'b0);
      check_out("collapse sampled", 1'b0, 1'b0, 8'd0, 1'b0);
      walk("collapse first", 100, 255, 1'b0);
      walk("collapse rewalk", -1, -1, 1'b0);
      finish_walk("collapse", 1'b0);
      check_int("collapse writes", wr_seen - wr0, 512);
      check_int("collapse done pulses", done_seen - dn0, 1);

      // Enable edges and flush during DONE, from the vector table.
      wr0 = wr_seen;
      dn0 = done_seen;
      for (int v = 0; v < 13; v++) begin
         step(vecs[v].flush, vecs[v].en);
         check_out(vecs[v].name, vecs[v].stall, vecs[v].wr_en, 8'd0, vecs[v].done);
         if (vecs[v].walk) walk(vecs[v].name, -1, -1, vecs[v].en);
      end
      check_int("table writes", wr_seen - wr0, 768);
      check_int("table done pulses", done_seen - dn0, 3);
`ifdef A25_FLUSH_STATS_EN
      check_int("count before mid-walk reset", int'(o_flush_count), 6);
`endif

      // Reset asserted while addr 50 is being written.
      step(1'b1, 1'b1);
      check_out("pre-reset flush", 1'b0, 1'b0, 8'd0, 1'b0);
      for (int i = 0; i <= 50; i++) begin
         step(1'b0, 1'b1);
         check_out($sformatf("pre-reset addr %0d", i), 1'b1, 1'b1, i[7:0], 1'b0);
      end
      i_reset_n = 1'b0;
      #1;
      check_out("reset mid-walk", 1'b1, 1'b0, 8'd0, 1'b0);
`ifdef A25_FLUSH_STATS_EN
      check_int("count in reset", int'(o_flush_count), 0);
`endif
      step(1'b0, 1'b1);
      check_out("reset held", 1'b1, 1'b0, 8'd0, 1'b0);
      i_reset_n = 1'b1;
      wr0 = wr_seen;
      dn0 = done_seen;
      step(1'b0, 1'b1);
      check_out("re-init cycle", 1'b1, 1'b0, 8'd0, 1'b0);
      walk("re-init", -1, -1, 1'b1);
      finish_walk("re-init", 1'b1);
      check_int("re-init writes", wr_seen - wr0, 256);

      // Three more flushes after reset.
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1);
         check_out($sformatf("stat flush %0d sampled", k), 1'b0, 1'b0, 8'd0, 1'b0);
         walk($sformatf("stat flush %0d", k), -1, -1, 1'b1);
         finish_walk($sformatf("stat flush %0d", k), 1'b1);
      end
      check_int("post-reset done pulses", done_seen - dn0, 4);
`ifdef A25_FLUSH_STATS_EN
      check_int("count after three flushes", int'(o_flush_count), 4);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
